// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-input round-robin arbiter.
// Holds the FSM state type, vector widths and the rotating priority search.
package arb_pkg;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First set bit of req at or after start, wrapping modulo NREQ; one-hot or zero.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDW-1:0]  start);
        logic [NREQ-1:0] pick;
        logic [IDW-1:0]  idx;
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = start + IDW'(i);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/onehot_enc_4to2.sv
// Combinational one-hot to binary index encoder; non-one-hot input yields 0.
module onehot_enc_4to2
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        idx = '0;
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin, lock-until-release arbiter for four requesters with registered grant.
// Optional forced rotation after HOLD_MAX held cycles is enabled by ARB_HOLD_LIMIT_EN.
//
// state | meaning
// IDLE  | no owner; any request is granted by search from rr_ptr
// BUSY  | one owner holds gnt until it drops req (or hold limit forces rotation)
module rr_arb4_ctrl
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld,
    output logic [IDW-1:0]  rr_ptr
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arb4_ctrl: HOLD_MAX out of range 2..255");
    end

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  id_d;
    logic [IDW-1:0]  ptr_d;
    logic            rearb;
    logic            owner_req;
    logic            others_req;
    logic            force_rot;

    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt;

    assign force_rot = (state_q == BUSY) && (hold_cnt == HOLD_LAST) && others_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (rearb) begin
            hold_cnt <= '0;
        end else if (state_q == BUSY && owner_req && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign force_rot = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        rearb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, rr_ptr);
                    rearb   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Searching from owner+1 leaves the owner last, so it only wins if alone.
                if (!owner_req || force_rot) begin
                    gnt_d   = rr_pick(req, gnt_id + 2'd1);
                    rearb   = 1'b1;
                    state_d = (|req) ? BUSY : IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    onehot_enc_4to2 u_enc (
        .onehot (gnt_d),
        .idx    (id_d)
    );

    assign ptr_d = (rearb && |gnt_d) ? id_d + 2'd1 : rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            gnt_vld <= |gnt_d;
            rr_ptr  <= ptr_d;
            if (|gnt_d) begin
                gnt_id <= id_d;
            end
        end
    end

endmodule
